// File: rtl/interrupt_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | interrupt_sequencer: injects return-PC pushes, vectors to the ISR and      |
// | restores PC/flags on RTI for a 16-bit-instruction pipeline.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module interrupt_sequencer #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0020,
  parameter logic [4:0]  RTI_OPCODE   = 5'b11110,
  parameter logic [15:0] PUSH_HI_INST = 16'hA000,
  parameter logic [15:0] PUSH_LO_INST = 16'hA001,
  parameter logic [15:0] NOP_INST     = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic [31:0] pc_next,
  input  logic [15:0] ifid_inst,
  input  logic        ifid_bubble,
  input  logic        branch_flush,
  output logic        inject_valid,
  output logic [15:0] inject_inst,
  output logic        fetch_hold,
  output logic        pc_sel,
  output logic [31:0] pc_override,
  output logic        save_flags,
  output logic        restore_flags,
  output logic        in_isr
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_HI = 3'd1,
    S_PUSH_LO = 3'd2,
    S_VECTOR  = 3'd3,
    S_ISR     = 3'd4,
    S_RETURN  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic        in_isr_q, in_isr_d;
  logic        rti_valid;
  logic        unused_inst_bits;

  // A flushed or bubbled RTI never reached decode, so it must not end the ISR.
  assign rti_valid        = (ifid_inst[15:11] == RTI_OPCODE) && !ifid_bubble && !branch_flush;
  assign unused_inst_bits = ^ifid_inst[10:0];

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | irq;
    ret_pc_d  = ret_pc_q;
    in_isr_d  = in_isr_q;
    case (state_q)
      S_IDLE: begin
        // During a flush pc_next is stale; wait for the corrected target.
        if ((pending_q || irq) && !branch_flush) begin
          state_d   = S_PUSH_HI;
          pending_d = 1'b0;
          ret_pc_d  = pc_next;
        end
      end
      S_PUSH_HI: state_d = S_PUSH_LO;
      S_PUSH_LO: state_d = S_VECTOR;
      S_VECTOR: begin
        state_d  = S_ISR;
        in_isr_d = 1'b1;
      end
      S_ISR: begin
        if (rti_valid) begin
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        state_d  = S_IDLE;
        in_isr_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      ret_pc_q  <= 32'h0;
      in_isr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ret_pc_q  <= ret_pc_d;
      in_isr_q  <= in_isr_d;
    end
  end

  always_comb begin
    inject_valid  = 1'b0;
    inject_inst   = NOP_INST;
    fetch_hold    = 1'b0;
    pc_sel        = 1'b0;
    pc_override   = 32'h0;
    save_flags    = 1'b0;
    restore_flags = 1'b0;
    case (state_q)
      S_PUSH_HI: begin
        inject_valid = 1'b1;
        inject_inst  = PUSH_HI_INST;
        fetch_hold   = 1'b1;
        save_flags   = 1'b1;
      end
      S_PUSH_LO: begin
        inject_valid = 1'b1;
        inject_inst  = PUSH_LO_INST;
        fetch_hold   = 1'b1;
      end
      S_VECTOR: begin
        pc_sel      = 1'b1;
        pc_override = VECTOR_ADDR;
      end
      S_RETURN: begin
        // Squash the RTI sitting in decode while the return PC is loaded.
        inject_valid  = 1'b1;
        inject_inst   = NOP_INST;
        pc_sel        = 1'b1;
        pc_override   = ret_pc_q;
        restore_flags = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_isr = in_isr_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_interrupt_sequencer: vector table, corner sequences and random checks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic [31:0] pc_next;
  logic [15:0] ifid_inst;
  logic        ifid_bubble;
  logic        branch_flush;
  logic        inject_valid;
  logic [15:0] inject_inst;
  logic        fetch_hold;
  logic        pc_sel;
  logic [31:0] pc_override;
  logic        save_flags;
  logic        restore_flags;
  logic        in_isr;

  int vectors     = 0;
  int miscompares = 0;

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .irq(irq), .pc_next(pc_next),
    .ifid_inst(ifid_inst), .ifid_bubble(ifid_bubble), .branch_flush(branch_flush),
    .inject_valid(inject_valid), .inject_inst(inject_inst), .fetch_hold(fetch_hold),
    .pc_sel(pc_sel), .pc_override(pc_override), .save_flags(save_flags),
    .restore_flags(restore_flags), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  // {inject_valid, inject_inst, fetch_hold, pc_sel, pc_override, save, restore, in_isr}
  localparam logic [53:0] E_IDLE = {1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,  3'b000};
  localparam logic [53:0] E_PHI  = {1'b1, 16'hA000, 1'b1, 1'b0, 32'h0,  3'b100};
  localparam logic [53:0] E_PLO  = {1'b1, 16'hA001, 1'b1, 1'b0, 32'h0,  3'b000};
  localparam logic [53:0] E_VEC  = {1'b0, 16'h0000, 1'b0, 1'b1, 32'h20, 3'b000};
  localparam logic [53:0] E_ISR  = {1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,  3'b001};

  function automatic logic [53:0] e_ret(input logic [31:0] po);
    return {1'b1, 16'h0000, 1'b0, 1'b1, po, 3'b011};
  endfunction

  function automatic logic [53:0] actual();
    return {inject_valid, inject_inst, fetch_hold, pc_sel, pc_override,
            save_flags, restore_flags, in_isr};
  endfunction

  task automatic chk(input string name, input logic [53:0] exp);
    logic [53:0] act;
    act = actual();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic i_irq, input logic [31:0] pc, input logic [15:0] inst,
                      input logic bub, input logic fl);
    irq = i_irq; pc_next = pc; ifid_inst = inst; ifid_bubble = bub; branch_flush = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: entry is a fixed 3-step script (push hi, push lo, vector)
  int          m_entry;
  bit          m_isr, m_ret, m_in_isr, m_pending;
  logic [31:0] m_retpc;

  task automatic model_reset();
    m_entry = 0; m_isr = 0; m_ret = 0; m_in_isr = 0; m_pending = 0; m_retpc = 32'h0;
  endtask

  function automatic logic [53:0] model_exp();
    logic [15:0] ii;
    logic [31:0] po;
    ii = (m_entry == 1) ? 16'hA000 : (m_entry == 2) ? 16'hA001 : 16'h0000;
    po = (m_entry == 3) ? 32'h20 : (m_ret ? m_retpc : 32'h0);
    return {(m_entry == 1 || m_entry == 2 || m_ret), ii, (m_entry == 1 || m_entry == 2),
            (m_entry == 3 || m_ret), po, (m_entry == 1), m_ret, m_in_isr};
  endfunction

  task automatic model_step(input logic i_irq, input logic [31:0] pc, input logic [15:0] inst,
                            input logic bub, input logic fl);
    bit idle, want;
    idle = (m_entry == 0) && !m_isr && !m_ret;
    want = m_pending || i_irq;
    m_pending = want;
    if (idle) begin
      if (want && !fl) begin
        m_entry = 1; m_retpc = pc; m_pending = 0;
      end
    end else if (m_entry == 1 || m_entry == 2) begin
      m_entry++;
    end else if (m_entry == 3) begin
      m_entry = 0; m_isr = 1; m_in_isr = 1;
    end else if (m_isr) begin
      if (inst[15:11] == 5'b11110 && !bub && !fl) begin
        m_isr = 0; m_ret = 1;
      end
    end else if (m_ret) begin
      m_ret = 0; m_in_isr = 0;
    end
  endtask

  typedef struct {
    logic        irq;
    logic [31:0] pc;
    logic [15:0] inst;
    logic        bub;
    logic        fl;
    logic [53:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0104, 16'h0000, 1'b0, 1'b0, E_PHI};
    tbl[1] = '{1'b0, 32'h0000_0104, 16'h0000, 1'b0, 1'b0, E_PLO};
    tbl[2] = '{1'b0, 32'h0000_0106, 16'h0000, 1'b0, 1'b0, E_VEC};
    tbl[3] = '{1'b0, 32'h0000_0020, 16'h0000, 1'b0, 1'b0, E_ISR};
    tbl[4] = '{1'b0, 32'h0000_0022, 16'hF000, 1'b1, 1'b0, E_ISR};
    tbl[5] = '{1'b0, 32'h0000_0024, 16'hF000, 1'b0, 1'b1, E_ISR};
    tbl[6] = '{1'b0, 32'h0000_0026, 16'hF000, 1'b0, 1'b0, e_ret(32'h0000_0104)};
    tbl[7] = '{1'b0, 32'h0000_0104, 16'h0000, 1'b0, 1'b0, E_IDLE};

    reset = 1'b1; irq = 0; pc_next = 0; ifid_inst = 0; ifid_bubble = 0; branch_flush = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", E_IDLE);
    reset = 1'b0;

    // Basic entry, ignored RTIs, return
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].irq, tbl[i].pc, tbl[i].inst, tbl[i].bub, tbl[i].fl);
      chk($sformatf("table_%0d", i), tbl[i].exp);
    end

    // Flush collision delays entry and captures the corrected PC
    step(1, 32'h0000_0200, 16'h0, 0, 1); chk("flush_hold1", E_IDLE);
    step(0, 32'h0000_0300, 16'h0, 0, 1); chk("flush_hold2", E_IDLE);
    step(0, 32'h0000_0300, 16'h0, 0, 0); chk("flush_entry", E_PHI);
    step(0, 32'h0000_0300, 16'h0, 0, 0); chk("flush_pushlo", E_PLO);
    step(0, 32'h0000_0300, 16'h0, 0, 0); chk("flush_vector", E_VEC);
    step(0, 32'h0000_0020, 16'h0, 0, 0); chk("flush_isr", E_ISR);

    // Nested request is held pending until after RETURN
    step(1, 32'h0000_0350, 16'h0, 0, 0);    chk("nest_no_inject", E_ISR);
    step(0, 32'h0000_0360, 16'hF000, 0, 0); chk("flush_retpc", e_ret(32'h0000_0300));
    step(0, 32'h0000_0400, 16'h0, 0, 0);    chk("nest_gap", E_IDLE);
    step(0, 32'h0000_0500, 16'h0, 0, 0);    chk("nest_entry", E_PHI);
    step(0, 32'h0000_0500, 16'h0, 0, 0);    chk("nest_pushlo", E_PLO);
    step(0, 32'h0000_0500, 16'h0, 0, 0);    chk("nest_vector", E_VEC);
    step(0, 32'h0000_0020, 16'h0, 0, 0);    chk("nest_isr", E_ISR);
    step(0, 32'h0000_0022, 16'hF7FF, 0, 0); chk("nest_retpc", e_ret(32'h0000_0500));
    step(0, 32'h0000_0500, 16'h0, 0, 0);    chk("nest_idle", E_IDLE);

    // Reset during PUSH_LO abandons the sequence
    step(1, 32'h0000_0600, 16'h0, 0, 0); chk("rst_seq_phi", E_PHI);
    step(0, 32'h0000_0600, 16'h0, 0, 0); chk("rst_seq_plo", E_PLO);
    reset = 1'b1;
    #1;
    chk("reset_async", E_IDLE);
    step(0, 32'h0000_0600, 16'h0, 0, 0); chk("reset_held", E_IDLE);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0000_0600, 16'hF000, 0, 0);
      chk("reset_no_vector", E_IDLE);
    end

    // Randomized run against the reference model
    reset = 1'b1;
    step(0, 32'h0, 16'h0, 0, 0);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r_irq, r_bub, r_fl;
      logic [31:0] r_pc;
      logic [15:0] r_inst;
      chk("random", model_exp());
      if ($urandom_range(99) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        chk("random_reset", model_exp());
        @(posedge clk);
        @(negedge clk);
        chk("random_reset_held", model_exp());
        reset = 1'b0;
      end
      r_irq  = ($urandom_range(7) == 0);
      r_pc   = $urandom;
      r_inst = $urandom;
      if ($urandom_range(3) == 0) r_inst[15:11] = 5'b11110;
      r_bub  = ($urandom_range(3) == 0);
      r_fl   = ($urandom_range(3) == 0);
      model_step(r_irq, r_pc, r_inst, r_bub, r_fl);
      step(r_irq, r_pc, r_inst, r_bub, r_fl);
    end
    chk("random_final", model_exp());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
